id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage for the five-stage RISC-V core. It registers the decoded control word from the Control_Unit together with the operands, immediate and register indices for the EX stage. It contains the load-use hazard detector whose combinational `stall` output drives the Control_Unit `stall` input and gates the PC and IF/ID register writes. It inserts bubbles on load-use stalls and on branch-taken flushes, and keeps saturating event counters.

## Interface
Parameters:
- XLEN, 64, datapath width of PC, operands and immediate
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  control word from Control_Unit
- id_ALUOp  in  2  ALU op class from Control_Unit
- id_pc  in  XLEN  PC of the instruction in ID
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices from IF/ID
- id_funct  in  4  {instr[30], instr[14:12]} for ALU control
- flush  in  1  branch taken, resolved downstream; squash the ID instruction
- ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered control
- ex_ALUOp  out  2  registered ALU op class
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered data
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices, used for forwarding
- ex_funct  out  4  registered funct bits
- ex_valid  out  1  EX holds a real instruction (0 = bubble)
- stall  out  1  combinational load-use hazard; feeds Control_Unit, PC write-enable (inverted) and IF/ID write-enable (inverted)
- stall_count  out  CNT_W  bubbles inserted due to stall, saturating
- flush_count  out  CNT_W  bubbles inserted due to flush, saturating

## Operation
- Hazard detection:
  - raw_hazard = ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Both rs fields are always compared, regardless of instruction format.
  - stall = raw_hazard & ~flush. Flush wins because the ID instruction is being discarded and the PC must redirect.
- Per-edge update, in priority order:
  1. flush = 1: load a bubble. flush_count increments unless it is saturated.
  2. stall = 1: load a bubble. stall_count increments unless it is saturated.
  3. Otherwise: capture every id_* input into the matching ex_* output, and set ex_valid = 1.
- Bubble: every ex_* output, including data and indices, is cleared to 0, and ex_valid = 0. The ID-side control word is ignored during a bubble, even though the Control_Unit already zeroes it under stall.
- No hold mode exists. The stage loads every cycle. Stall freezes only the upstream stages (PC, IF/ID), so the stalled instruction re-presents in ID next cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.
- A bubble in EX (ex_valid = 0) can never raise stall. One load-use stall therefore lasts exactly one cycle.

## Timing
- Latency: one clock from ID inputs to ex_* outputs.
- stall is combinational, valid in the same cycle from registered ex_* and current id_rs1/id_rs2. It does not depend on id control inputs, so there is no combinational loop through the Control_Unit.
- Reset (rst_n low, asynchronous): all ex_* outputs = 0, ex_valid = 0, both counters = 0. stall therefore reads 0 during reset.
- A reset asserted mid-stall clears the state immediately. The first cycle after release loads ID normally.
- Back-to-back loads, each consuming the previous one, produce alternating stall/issue cycles: one bubble per dependent pair.
- flush and raw_hazard in the same cycle: stall = 0, one bubble, only flush_count increments.

## Test plan
- Reset: rst_n low asynchronously mid-cycle → all ex_* = 0, ex_valid = 0, stall = 0, both counters = 0 before the next edge.
- Pass-through: present `add x3,x1,x2` (RegWrite = 1, ALUOp = 10, rs1 = 1, rs2 = 2, rd = 3, rs1_data = 0x11, rs2_data = 0x22) → next edge ex_RegWrite = 1, ex_ALUOp = 10, ex_rd = 3, ex_rs1_data = 0x11, ex_valid = 1, stall = 0.
- Load-use: `ld x5,0(x1)` then `add x6,x5,x7` in ID → stall = 1 for exactly one cycle. The next edge gives ex_valid = 0 and stall_count = 1. The following edge gives the add with ex_valid = 1 and ex_rd = 6.
- No false hazard:
  - `ld x0,...` followed by a use of x0 → stall = 0.
  - `addi x5` followed by a use of x5 → stall = 0.
  - ld x5 followed by add x6,x8,x9 → stall = 0.
- Flush priority: with the load-use condition active, assert flush → stall = 0 that cycle, the next edge gives ex_valid = 0, flush_count = 1, stall_count unchanged.
- Saturation: with CNT_W = 4, force 20 load-use stalls → stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and saturating counters for the bubbles each cause inserts.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_branch,
    input  logic             id_MemRead,
    input  logic             id_MemtoReg,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_RegWrite,
    input  logic [1:0]       id_ALUOp,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    output logic             ex_branch,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [1:0]       ex_ALUOp,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic             ex_valid,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic       raw_hazard;
    logic       bubble;
    logic [1:0] cnt_inc;

    // Only registered EX state and ID register indices feed this, so there is
    // no path back through the Control_Unit's control word.
    assign raw_hazard = ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign stall      = raw_hazard & ~flush;
    assign bubble     = flush | stall;
    assign cnt_inc    = {stall, flush};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_branch   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUOp    <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
        end else if (bubble) begin
            ex_branch   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUOp    <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
        end else begin
            ex_branch   <= id_branch;
            ex_MemRead  <= id_MemRead;
            ex_MemtoReg <= id_MemtoReg;
            ex_MemWrite <= id_MemWrite;
            ex_ALUSrc   <= id_ALUSrc;
            ex_RegWrite <= id_RegWrite;
            ex_ALUOp    <= id_ALUOp;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            ex_valid    <= 1'b1;
        end
    end

    // Index 0 counts flush bubbles, index 1 stall bubbles; both hold at all-ones.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign flush_count = g_cnt[0].cnt_reg;
    assign stall_count = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: a transaction-level model predicts stall
// and the EX contents; a separate monitor pops and compares each cycle.
module tb_id_ex_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic            branch, memread, memtoreg, memwrite, alusrc, regwrite;
        logic [1:0]      aluop;
        logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      funct;
    } inst_t;

    typedef struct packed {
        inst_t            i;
        logic             valid;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic id_branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [1:0] id_ALUOp;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_funct;
    logic flush;
    logic ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [1:0] ex_ALUOp;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_funct;
    logic ex_valid, stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_branch(id_branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .ex_branch(ex_branch), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
        .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_valid(ex_valid), .stall(stall),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    exp_t m = '0;
    exp_t ex_q[$];
    logic stall_q[$];

    function automatic exp_t dut_state();
        exp_t e;
        e.i.branch   = ex_branch;   e.i.memread  = ex_MemRead;
        e.i.memtoreg = ex_MemtoReg; e.i.memwrite = ex_MemWrite;
        e.i.alusrc   = ex_ALUSrc;   e.i.regwrite = ex_RegWrite;
        e.i.aluop    = ex_ALUOp;    e.i.pc       = ex_pc;
        e.i.rs1_data = ex_rs1_data; e.i.rs2_data = ex_rs2_data;
        e.i.imm      = ex_imm;      e.i.rs1      = ex_rs1;
        e.i.rs2      = ex_rs2;      e.i.rd       = ex_rd;
        e.i.funct    = ex_funct;    e.valid      = ex_valid;
        e.sc         = stall_count; e.fc         = flush_count;
        return e;
    endfunction

    task automatic drive(input inst_t t);
        id_branch   = t.branch;   id_MemRead  = t.memread;
        id_MemtoReg = t.memtoreg; id_MemWrite = t.memwrite;
        id_ALUSrc   = t.alusrc;   id_RegWrite = t.regwrite;
        id_ALUOp    = t.aluop;    id_pc       = t.pc;
        id_rs1_data = t.rs1_data; id_rs2_data = t.rs2_data;
        id_imm      = t.imm;      id_rs1      = t.rs1;
        id_rs2      = t.rs2;      id_rd       = t.rd;
        id_funct    = t.funct;
    endtask

    // A load-use hazard exists when the instruction in EX is a real load
    // writing a nonzero register that the ID instruction reads.
    function automatic logic hazard(input inst_t t);
        return m.valid && m.i.memread && (m.i.rd != 5'd0) &&
               (m.i.rd == t.rs1 || m.i.rd == t.rs2);
    endfunction

    function automatic inst_t rnd_inst();
        inst_t t;
        t = '0;
        {t.branch, t.memtoreg, t.memwrite, t.alusrc, t.regwrite} = 5'($urandom);
        t.memread  = ($urandom_range(0, 1) == 1);
        t.aluop    = 2'($urandom);
        t.pc       = {$urandom, $urandom};
        t.rs1_data = {$urandom, $urandom};
        t.rs2_data = {$urandom, $urandom};
        t.imm      = {$urandom, $urandom};
        t.rs1      = 5'($urandom_range(0, 7));
        t.rs2      = 5'($urandom_range(0, 7));
        t.rd       = 5'($urandom_range(0, 7));
        t.funct    = 4'($urandom);
        return t;
    endfunction

    function automatic inst_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic memread);
        inst_t t;
        t = rnd_inst();
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.memread = memread;
        t.regwrite = 1'b1;
        return t;
    endfunction

    // One ID cycle: drive, predict stall and the resulting EX state, enqueue.
    task automatic issue(input inst_t t, input logic fl, output logic st);
        @(negedge clk);
        drive(t);
        flush = fl;
        st = hazard(t) && !fl;
        stall_q.push_back(st);
        if (fl) begin
            m.i = '0; m.valid = 1'b0;
            if (m.fc != {CNT_W{1'b1}}) m.fc = m.fc + 1'b1;
        end else if (st) begin
            m.i = '0; m.valid = 1'b0;
            if (m.sc != {CNT_W{1'b1}}) m.sc = m.sc + 1'b1;
        end else begin
            m.i = t; m.valid = 1'b1;
        end
        ex_q.push_back(m);
        txn++;
        $display("txn %0d rs1=%0d rs2=%0d rd=%0d ld=%0b flush=%0b exp_stall=%0b exp_valid=%0b sc=%0d fc=%0d",
                 txn, t.rs1, t.rs2, t.rd, t.memread, fl, st, m.valid, m.sc, m.fc);
    endtask

    // Present the instruction again after a stall, as the frozen IF/ID would.
    task automatic issue_hold(input inst_t t);
        logic st;
        issue(t, 1'b0, st);
        if (st) issue(t, 1'b0, st);
    endtask

    // Asynchronous reset mid-cycle with pre in ID; checks stall just before and
    // the cleared state just after rst_n falls.
    task automatic do_reset(input inst_t pre);
        logic exp_st;
        @(posedge clk);
        #2;
        drive(pre);
        flush = 1'b0;
        exp_st = hazard(pre);
        #1;
        checks++;
        if (stall !== exp_st) begin
            errors++;
            $display("FAIL pre_reset_stall got=%0b exp=%0b", stall, exp_st);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_state() !== exp_t'(0) || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%h stall=%0b exp=0", dut_state(), stall);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m = '0;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t g;
        logic s;
        forever begin
            @(negedge clk);
            #3;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                checks++;
                if (stall !== s) begin
                    errors++;
                    $display("FAIL stall got=%0b exp=%0b at %0t", stall, s, $time);
                end
            end
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                e = ex_q.pop_front();
                g = dut_state();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL ex_state at %0t got=%h exp=%h", $time, g, e);
                end
            end
        end
    end

    initial begin : stimulus
        inst_t t, ld, use_i;
        logic st;
        drive('0);
        flush = 1'b0;
        #12;
        do_reset('0);

        // add x3,x1,x2 pass-through
        t = '0;
        t.regwrite = 1'b1; t.aluop = 2'b10; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd = 5'd3;
        t.rs1_data = 64'h11; t.rs2_data = 64'h22;
        issue(t, 1'b0, st);

        // ld x5 then add x6,x5,x7: one stall, then the add issues
        ld    = mk(5'd1, 5'd0, 5'd5, 1'b1);
        use_i = mk(5'd5, 5'd7, 5'd6, 1'b0);
        issue(ld, 1'b0, st);
        issue_hold(use_i);

        // No false hazards
        issue(mk(5'd1, 5'd2, 5'd0, 1'b1), 1'b0, st);
        issue(mk(5'd0, 5'd0, 5'd9, 1'b0), 1'b0, st);
        issue(mk(5'd1, 5'd2, 5'd5, 1'b0), 1'b0, st);
        issue(mk(5'd5, 5'd5, 5'd6, 1'b0), 1'b0, st);
        issue(mk(5'd1, 5'd2, 5'd5, 1'b1), 1'b0, st);
        issue(mk(5'd8, 5'd9, 5'd6, 1'b0), 1'b0, st);

        // Flush beats load-use
        issue(ld, 1'b0, st);
        issue(use_i, 1'b1, st);
        issue(use_i, 1'b0, st);

        // Reset while a load-use stall is active, then a normal load
        issue(ld, 1'b0, st);
        do_reset(use_i);
        issue(use_i, 1'b0, st);

        // Saturation: 20 dependent pairs with a 4-bit counter
        do_reset('0);
        for (int k = 0; k < 20; k++) begin
            issue(ld, 1'b0, st);
            issue_hold(use_i);
        end
        @(posedge clk);
        #2;
        checks++;
        if (stall_count !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat got=%0d exp=15", stall_count);
        end

        // Random traffic with dense register reuse and occasional flushes
        do_reset('0);
        t = rnd_inst();
        for (int k = 0; k < 400; k++) begin
            issue(t, ($urandom_range(0, 7) == 0), st);
            if (!st) t = rnd_inst();
        end

        for (int k = 0; k < 4 && (ex_q.size() > 0 || stall_q.size() > 0); k++)
            @(posedge clk);
        #3;
        checks++;
        if (ex_q.size() != 0 || stall_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d exp=0/0", ex_q.size(), stall_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
